// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: loads and non-destructively reads back a tile configuration chain
//   prog_clk, pReset                : configuration clock, asynchronous active-low reset
//   op_start, op_read               : one-cycle op request and select (0 = write, 1 = read), sampled in idle
//   wr_data, wr_valid, wr_ready     : host bitstream words for write ops
//   rd_data, rd_valid, rd_ready     : readback words for read ops
//   chain_shift_en, ccff_head/tail  : chain shift gate and serial chain pins
//   busy, done                      : op in progress, one-cycle completion pulse
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 65,
  parameter int WORD_W    = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              op_start,
  input  logic              op_read,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              chain_shift_en,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFETCH = 3'd1;
  localparam logic [2:0] S_WSHIFT = 3'd2;
  localparam logic [2:0] S_RSHIFT = 3'd3;
  localparam logic [2:0] S_ROUT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   wb_q, wb_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  // Outputs decode straight from the state register so an asynchronous
  // reset forces every output low immediately.
  assign wr_ready       = state_q == S_WFETCH;
  assign rd_valid       = state_q == S_ROUT;
  assign rd_data        = rd_valid ? sh_q : '0;
  assign chain_shift_en = state_q == S_WSHIFT || state_q == S_RSHIFT;
  // Read rotates the chain: the tail bit is fed back into the head.
  assign ccff_head      = state_q == S_WSHIFT ? sh_q[0] : state_q == S_RSHIFT ? ccff_tail : 1'b0;
  assign busy           = state_q != S_IDLE && state_q != S_DONE;
  assign done           = state_q == S_DONE;
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wb_d      = wb_q;
    sh_d      = sh_q;
    case (state_q)
      S_IDLE: if (op_start) begin
        state_d   = op_read ? S_RSHIFT : S_WFETCH;
        bit_cnt_d = '0;
        wb_d      = '0;
        sh_d      = '0;
      end
      S_WFETCH: if (wr_valid) begin
        sh_d    = wr_data;
        wb_d    = '0;
        state_d = S_WSHIFT;
      end
      S_WSHIFT: begin
        sh_d      = sh_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        wb_d      = wb_q + 1'b1;
        // Chain end wins over word end, which drops the padding of the last word.
        state_d   = bit_cnt_q == CNT_LAST ? S_DONE : wb_q == WB_LAST ? S_WFETCH : S_WSHIFT;
      end
      S_RSHIFT: begin
        sh_d      = sh_q | (WORD_W'(ccff_tail) << wb_q);
        bit_cnt_d = bit_cnt_q + 1'b1;
        wb_d      = wb_q + 1'b1;
        state_d   = (bit_cnt_q == CNT_LAST || wb_q == WB_LAST) ? S_ROUT : S_RSHIFT;
      end
      S_ROUT: if (rd_ready) begin
        sh_d    = '0;
        wb_d    = '0;
        state_d = bit_cnt_q == CNT_FULL ? S_DONE : S_RSHIFT;
      end
      S_DONE: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      wb_q      <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wb_q      <= wb_d;
      sh_q      <= sh_d;
    end
  end
endmodule
